// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and wait-counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised storage: synchronous byte-lane write, combinational read, no reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wd,
    output logic [31:0]      rd
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    mem[idx][lane*8 +: 8] <= wd[lane*8 +: 8];
                end
            end
        end
    end

    assign rd = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states and
// alignment / range error reporting.
//
//   state | meaning
//   IDLE  | ready=1, accepts req and registers the access
//   WAIT  | counting down WAIT_STATES cycles, req ignored
//   RESP  | ack=1 for one cycle, write committed on this edge if err=0
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rd,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t           state, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [3:0]  be_q;

    logic        accept;
    logic        err_raw;
    logic        ram_wr_en;
    logic [31:0] ram_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_CNT_W'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                wait_cnt_next = wait_cnt - 1'b1;
                if (wait_cnt <= WAIT_CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Request registers hold the access for the whole WAIT/RESP window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
            be_q   <= '0;
        end else if (accept) begin
            we_q   <= we;
            addr_q <= addr;
            wd_q   <= wd;
            be_q   <= be;
        end
    end

    // Out-of-range compares the full word index, so high addresses never alias.
    always_comb begin
        err_raw = 1'b0;
        if (addr_q[1:0] != 2'b00) begin
            err_raw = 1'b1;
        end
        if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) begin
            err_raw = 1'b1;
        end
    end

    assign ready     = (state == IDLE);
    assign ack       = (state == RESP);
    assign err       = ack & err_raw;
    assign ram_wr_en = ack & we_q & ~err_raw;
    assign rd        = (ack && !we_q && !err_raw) ? ram_rd : 32'h0;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .wr_en (ram_wr_en),
        .be    (be_q),
        .idx   (addr_q[IDX_W+1:2]),
        .wd    (wd_q),
        .rd    (ram_rd)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: drivers queue the expected response, per-instance monitors pop on ack.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instance with one wait state
    logic        rst1_n = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wd1 = '0;
    logic [3:0]  be1 = '0;
    logic        ready1, ack1, err1;
    logic [31:0] rd1;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst1_n), .req(req1), .we(we1), .addr(addr1), .wd(wd1), .be(be1),
        .ready(ready1), .ack(ack1), .rd(rd1), .err(err1)
    );

    // Instance with zero wait states
    logic        rst0_n = 1'b0, req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic [3:0]  be0 = '0;
    logic        ready0, ack0, err0;
    logic [31:0] rd0;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst0_n), .req(req0), .we(we0), .addr(addr0), .wd(wd0), .be(be0),
        .ready(ready0), .ack(ack0), .rd(rd0), .err(err0)
    );

    exp_t q1[$];
    exp_t q0[$];
    int   acks1 = 0, accepts1 = 0;
    int   acks0 = 0, accepts0 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (ack1) begin
            acks1++;
            if (q1.size() == 0) begin
                chk("dut1 unexpected ack", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1 rd", rd1, e.rd);
                chk("dut1 err", {31'd0, err1}, {31'd0, e.err});
                chk("dut1 ack latency", cyc, e.cyc);
            end
        end else begin
            chk("dut1 idle rd/err", {rd1[31:1], rd1[0] | err1}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ack0) begin
            acks0++;
            if (q0.size() == 0) begin
                chk("dut0 unexpected ack", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0 rd", rd0, e.rd);
                chk("dut0 err", {31'd0, err0}, {31'd0, e.err});
                chk("dut0 ack latency", cyc, e.cyc);
            end
        end
    end

    // Waits (bounded) for dut1 idle at a negedge, presents one access for one cycle.
    task automatic wait_ready1();
        int n = 0;
        @(negedge clk);
        while (ready1 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("dut1 ready timeout", 32'd0, 32'd1);
    endtask

    task automatic access1(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        wait_ready1();
        req1 = 1'b1; we1 = w; addr1 = a; wd1 = d; be1 = b;
        e.rd = exp_rd; e.err = exp_err; e.cyc = cyc + 2;
        q1.push_back(e);
        accepts1++;
        @(negedge clk);
        req1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain timeout", 32'd0, 32'd1);
    endtask

    initial begin
        exp_t e;
        logic exp_ready [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        @(negedge clk);
        chk("reset ready", {31'd0, ready1}, 32'd1);
        chk("reset ack", {31'd0, ack1}, 32'd0);
        chk("reset err", {31'd0, err1}, 32'd0);
        chk("reset rd", rd1, 32'd0);
        rst1_n = 1'b1;
        rst0_n = 1'b1;

        // full write then read back
        access1(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        access1(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        // partial write: lanes 0 and 2
        access1(1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        access1(1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);
        // misaligned read
        access1(1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
        // out-of-range write must not touch the top word nor wrap to word 0
        access1(1'b1, 32'h0FC, 32'hA5A50FC0, 4'hF, 32'h0, 1'b0);
        access1(1'b1, 32'h000, 32'h00001111, 4'hF, 32'h0, 1'b0);
        access1(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        access1(1'b0, 32'h0FC, 32'h0, 4'h0, 32'hA5A50FC0, 1'b0);
        access1(1'b0, 32'h000, 32'h0, 4'h0, 32'h00001111, 1'b0);
        // be=0 write completes and changes nothing
        access1(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        access1(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
        // misaligned write would land on word 0x10 if not blocked
        access1(1'b1, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
        access1(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
        // reset during WAIT discards the pending write
        access1(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0);
        wait_ready1();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wd1 = 32'hCAFEF00D; be1 = 4'hF;
        @(negedge clk);
        req1 = 1'b0;
        chk("in WAIT ready", {31'd0, ready1}, 32'd0);
        rst1_n = 1'b0;
        #1;
        chk("async reset ready", {31'd0, ready1}, 32'd1);
        chk("async reset ack", {31'd0, ack1}, 32'd0);
        @(negedge clk);
        rst1_n = 1'b1;
        access1(1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);
        // req held through WAIT and RESP with a corrupting write that must be ignored
        wait_ready1();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10;
        e.rd = 32'hDE22BE44; e.err = 1'b0; e.cyc = cyc + 2;
        q1.push_back(e);
        accepts1++;
        @(negedge clk);
        we1 = 1'b1; addr1 = 32'h20; wd1 = 32'h0; be1 = 4'hF;
        @(negedge clk);
        @(negedge clk);
        req1 = 1'b0;
        access1(1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);

        // zero wait states, req held high: write twice then read twice
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("dut0 ready pattern", {31'd0, ready0}, {31'd0, exp_ready[k]});
            req0 = 1'b1;
            we0 = (k < 4);
            addr0 = 32'h4;
            wd0 = 32'h55AA55AA;
            be0 = 4'hF;
            if (exp_ready[k]) begin
                e.rd = (k < 4) ? 32'h0 : 32'h55AA55AA;
                e.err = 1'b0;
                e.cyc = cyc + 1;
                q0.push_back(e);
                accepts0++;
            end
            @(negedge clk);
        end
        req0 = 1'b0;

        drain();
        repeat (4) @(negedge clk);
        chk("dut1 ack count", acks1, accepts1);
        chk("dut0 ack count", acks0, accepts0);
        chk("dut1 queue empty", q1.size(), 32'd0);
        chk("dut0 queue empty", q0.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: cycle %0d reached without finishing", cyc);
        $fatal(1);
    end

endmodule
